// File: rtl/change_dispense_sequencer.sv
// Coin-return hopper sequencer: dispenses a nickel-unit amount, preferring dimes,
// one confirmed coin at a time. Optional hopper watchdog via `define HOPPER_TIMEOUT_EN.
module change_dispense_sequencer #(
    parameter int AMT_W       = 4,
    parameter int CNT_W       = 8,
    parameter int HOP_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_dimes,
    input  logic [CNT_W-1:0] load_nickels,
    output logic             hop10_fire,
    output logic             hop5_fire,
    input  logic             hop_done,
    input  logic             clear_fault,
    output logic             busy,
    output logic             done,
    output logic             short_fault,
    output logic [AMT_W-1:0] owed,
    output logic [CNT_W-1:0] dime_cnt,
    output logic [CNT_W-1:0] nickel_cnt
);

    if (HOP_TIMEOUT < 2) begin : g_bad_timeout
        $error("HOP_TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_FIRE,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AMT_W-1:0] remaining;
    logic             coin_dime;
    logic             pick_dime;
    logic             can_fire;
    logic             timeout;

    // Dimes only while at least two nickels' worth is still owed.
    assign pick_dime = (remaining >= AMT_W'(2)) && (dime_cnt != '0);
    assign can_fire  = pick_dime || (nickel_cnt != '0);

`ifdef HOPPER_TIMEOUT_EN
    localparam int TMR_W = (HOP_TIMEOUT > 2) ? $clog2(HOP_TIMEOUT) : 1;

    logic [TMR_W-1:0] timer;

    // The cycle whose count reaches HOP_TIMEOUT-1 faults; a same-cycle hop_done wins.
    assign timeout = (state == S_WAIT) && !hop_done && (timer == TMR_W'(HOP_TIMEOUT - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state == S_FIRE) begin
            timer <= '0;
        end else if (state == S_WAIT) begin
            timer <= timer + TMR_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        busy        = 1'b1;
        hop10_fire  = 1'b0;
        hop5_fire   = 1'b0;
        done        = 1'b0;
        short_fault = 1'b0;
        owed        = '0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                if (remaining == '0) begin
                    state_nxt = S_DONE;
                end else if (can_fire) begin
                    state_nxt = S_FIRE;
                end else begin
                    state_nxt = S_FAULT;
                end
            end
            S_FIRE: begin
                hop10_fire = coin_dime;
                hop5_fire  = !coin_dime;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (hop_done) begin
                    state_nxt = S_SELECT;
                end else if (timeout) begin
                    state_nxt = S_FAULT;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_FAULT: begin
                short_fault = 1'b1;
                owed        = remaining;
                if (clear_fault) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Amount and inventory bookkeeping, driven by the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining  <= '0;
            dime_cnt   <= '0;
            nickel_cnt <= '0;
            coin_dime  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (load_en) begin
                        dime_cnt   <= load_dimes;
                        nickel_cnt <= load_nickels;
                    end
                    if (req_valid) begin
                        remaining <= req_amount;
                    end
                end
                S_SELECT: begin
                    coin_dime <= pick_dime;
                end
                S_WAIT: begin
                    if (hop_done) begin
                        if (coin_dime) begin
                            remaining <= remaining - AMT_W'(2);
                            dime_cnt  <= dime_cnt - CNT_W'(1);
                        end else begin
                            remaining  <= remaining - AMT_W'(1);
                            nickel_cnt <= nickel_cnt - CNT_W'(1);
                        end
                    end
                end
                S_FAULT: begin
                    if (clear_fault) begin
                        remaining <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispense_sequencer.sv
// Bench for change_dispense_sequencer: directed scenarios plus randomized requests
// checked against a closed-form greedy coin model.
module tb_change_dispense_sequencer;

    localparam int AMT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             load_en;
    logic [CNT_W-1:0] load_dimes;
    logic [CNT_W-1:0] load_nickels;
    logic             hop10_fire;
    logic             hop5_fire;
    logic             hop_done;
    logic             clear_fault;
    logic             busy;
    logic             done;
    logic             short_fault;
    logic [AMT_W-1:0] owed;
    logic [CNT_W-1:0] dime_cnt;
    logic [CNT_W-1:0] nickel_cnt;

    change_dispense_sequencer #(
        .AMT_W(AMT_W),
        .CNT_W(CNT_W),
        .HOP_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_amount(req_amount),
        .req_ready(req_ready),
        .load_en(load_en),
        .load_dimes(load_dimes),
        .load_nickels(load_nickels),
        .hop10_fire(hop10_fire),
        .hop5_fire(hop5_fire),
        .hop_done(hop_done),
        .clear_fault(clear_fault),
        .busy(busy),
        .done(done),
        .short_fault(short_fault),
        .owed(owed),
        .dime_cnt(dime_cnt),
        .nickel_cnt(nickel_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference inventory
    int m_dimes = 0;
    int m_nickels = 0;

    // Observations of the most recent dispense
    int r_nd, r_nn;
    bit r_done, r_fault, r_order_bad, r_both, r_ready_bad, r_stuck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Drive one request and play the hoppers until done or fault.
    task automatic dispense(input int amt, input bit do_load, input int ld_d, input int ld_n,
                            input int dly_max, input bit disturb);
        int  wait_n;
        bit  seen_nickel;
        r_nd = 0; r_nn = 0;
        r_done = 0; r_fault = 0; r_order_bad = 0; r_both = 0; r_ready_bad = 0;
        r_stuck = 1;
        wait_n = 0;
        seen_nickel = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = AMT_W'(amt);
        if (do_load) begin
            load_en      = 1'b1;
            load_dimes   = CNT_W'(ld_d);
            load_nickels = CNT_W'(ld_n);
        end
        @(negedge clk);
        req_valid = 1'b0;
        load_en   = 1'b0;
        if (disturb) begin
            req_valid    = 1'b1;
            req_amount   = AMT_W'(7);
            load_en      = 1'b1;
            load_dimes   = CNT_W'(99);
            load_nickels = CNT_W'(99);
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            hop_done = 1'b0;
            if (wait_n > 0) begin
                wait_n--;
                if (wait_n == 0) hop_done = 1'b1;
            end
            if (disturb && req_ready) r_ready_bad = 1;
            if (hop10_fire && hop5_fire) r_both = 1;
            if (hop10_fire) begin
                r_nd++;
                if (seen_nickel) r_order_bad = 1;
                wait_n = 1 + int'($urandom_range(0, dly_max));
            end
            if (hop5_fire) begin
                r_nn++;
                seen_nickel = 1;
                wait_n = 1 + int'($urandom_range(0, dly_max));
            end
            if (done) begin
                r_done = 1; r_stuck = 0;
                break;
            end
            if (short_fault) begin
                r_fault = 1; r_stuck = 0;
                break;
            end
            @(negedge clk);
        end
        hop_done  = 1'b0;
        req_valid = 1'b0;
        load_en   = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input int amt, input bit do_load,
                                 input int ld_d, input int ld_n, input int dly_max,
                                 input bit disturb);
        int ed, en, rest, eowed;
        if (do_load) begin
            m_dimes   = ld_d;
            m_nickels = ld_n;
        end
        ed    = imin(amt / 2, m_dimes);
        rest  = amt - 2 * ed;
        en    = imin(rest, m_nickels);
        eowed = rest - en;
        dispense(amt, do_load, ld_d, ld_n, dly_max, disturb);
        chk({tag, " finished"}, 32'(r_stuck), 32'(0));
        chk({tag, " dime pulses"}, 32'(r_nd), 32'(ed));
        chk({tag, " nickel pulses"}, 32'(r_nn), 32'(en));
        chk({tag, " dimes first"}, 32'(r_order_bad), 32'(0));
        chk({tag, " both fire"}, 32'(r_both), 32'(0));
        chk({tag, " fault"}, 32'(r_fault), 32'(eowed != 0));
        if (r_fault) begin
            chk({tag, " owed"}, 32'(owed), 32'(eowed));
            @(negedge clk);
            chk({tag, " fault held"}, 32'(short_fault), 32'(1));
            chk({tag, " owed held"}, 32'(owed), 32'(eowed));
            clear_fault = 1'b1;
            @(negedge clk);
            clear_fault = 1'b0;
            chk({tag, " cleared ready"}, 32'(req_ready), 32'(1));
            chk({tag, " cleared fault"}, 32'(short_fault), 32'(0));
        end else begin
            chk({tag, " done"}, 32'(r_done), 32'(1));
            chk({tag, " owed zero"}, 32'(owed), 32'(0));
            @(negedge clk);
            chk({tag, " done pulse"}, 32'(done), 32'(0));
            chk({tag, " idle ready"}, 32'(req_ready), 32'(1));
        end
        if (disturb) chk({tag, " ready low busy"}, 32'(r_ready_bad), 32'(0));
        m_dimes   -= ed;
        m_nickels -= en;
        chk({tag, " dime_cnt"}, 32'(dime_cnt), 32'(m_dimes));
        chk({tag, " nickel_cnt"}, 32'(nickel_cnt), 32'(m_nickels));
    endtask

    initial begin
        int  fire_seen;
        int  stray;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_amount   = '0;
        load_en      = 1'b0;
        load_dimes   = '0;
        load_nickels = '0;
        hop_done     = 1'b0;
        clear_fault  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'(1));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset dime_cnt", 32'(dime_cnt), 32'(0));
        chk("reset nickel_cnt", 32'(nickel_cnt), 32'(0));
        chk("reset owed", 32'(owed), 32'(0));
        chk("reset fires", 32'({hop10_fire, hop5_fire, done, short_fault}), 32'(0));
        rst = 1'b0;

        run_and_check("t1 25c", 5, 1, 5, 5, 0, 0);
        run_and_check("t2 nickels only", 3, 1, 0, 4, 0, 0);
        run_and_check("t3 short", 3, 1, 1, 0, 0, 0);
        run_and_check("t4 busy disturb", 4, 1, 3, 2, 1, 1);
        run_and_check("t5 zero amount", 0, 0, 0, 0, 0, 0);

        // Reset while waiting on the first dime
        @(negedge clk);
        req_valid = 1'b1; req_amount = AMT_W'(3);
        load_en = 1'b1; load_dimes = CNT_W'(4); load_nickels = CNT_W'(4);
        @(negedge clk);
        req_valid = 1'b0; load_en = 1'b0;
        fire_seen = 0;
        for (int i = 0; i < 20 && fire_seen == 0; i++) begin
            if (hop10_fire) fire_seen = 1;
            else @(negedge clk);
        end
        chk("rst first dime fired", 32'(fire_seen), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst async ready", 32'(req_ready), 32'(1));
        chk("rst async busy", 32'(busy), 32'(0));
        chk("rst dime_cnt", 32'(dime_cnt), 32'(0));
        chk("rst nickel_cnt", 32'(nickel_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            hop_done = (i % 2 == 0);
            @(negedge clk);
            if (hop10_fire || hop5_fire || done || busy) stray++;
        end
        hop_done = 1'b0;
        chk("rst no activity after", 32'(stray), 32'(0));
        chk("rst stray hop_done dime_cnt", 32'(dime_cnt), 32'(0));
        chk("rst stray hop_done nickel_cnt", 32'(nickel_cnt), 32'(0));
        m_dimes = 0;
        m_nickels = 0;

        for (int n = 0; n < 25; n++) begin
            bit do_ld;
            do_ld = (n == 0) || ($urandom_range(0, 2) != 0);
            run_and_check($sformatf("rnd%0d", n), int'($urandom_range(0, 15)), do_ld,
                          int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                          int'($urandom_range(0, 3)), bit'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispense_sequencer.md
Name: change_dispense_sequencer

Overview:
- Sequences the physical coin-return hoppers for the vending controller.
- Accepts a refund or change amount in nickel units over a valid/ready handshake.
- Issues one-coin fire pulses to the 10C and 5C hoppers, preferring dimes, and waits for each hopper's confirmation before issuing the next pulse.
- Tracks dime and nickel inventory; flags a fault when inventory or a hopper cannot complete the amount.

Parameters:
- AMT_W, 4, width of the requested amount in 5-cent units (max 15 = 75 cents)
- CNT_W, 8, width of each coin inventory counter
- HOP_TIMEOUT, 16, cycles to wait for hop_done before faulting (only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  dispense request valid
- req_amount  in  AMT_W  amount to dispense, in nickels
- req_ready  out  1  high only in IDLE; the request is accepted on req_valid && req_ready
- load_en  in  1  inventory load strobe, honoured only in IDLE
- load_dimes  in  CNT_W  dime count loaded on load_en
- load_nickels  in  CNT_W  nickel count loaded on load_en
- hop10_fire  out  1  one-cycle pulse: release one dime
- hop5_fire  out  1  one-cycle pulse: release one nickel
- hop_done  in  1  hopper confirms that the fired coin left
- clear_fault  in  1  exits FAULT
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: request fully dispensed
- short_fault  out  1  high while in FAULT
- owed  out  AMT_W  undispensed remainder; valid in FAULT, 0 otherwise
- dime_cnt  out  CNT_W  current dime inventory
- nickel_cnt  out  CNT_W  current nickel inventory

Behaviour:
- Reset: clk is the single clock; rst is asynchronous, active-high. State goes to IDLE. remaining, dime_cnt and nickel_cnt clear to 0. All outputs are 0 except req_ready=1. Reset mid-dispense abandons the request, and no further fire pulse is issued.
- Outputs are Moore-decoded from registered state and counters; no combinational path from input to output.
- IDLE:
  - On load_en, counters take the load values.
  - On accept, remaining <= req_amount and the FSM goes to SELECT.
  - load_en and an accept in the same cycle are both honoured; SELECT sees the loaded counts.
- SELECT (1 cycle):
  - remaining==0 -> DONE.
  - Else remaining>=2 and dime_cnt>0 -> FIRE with coin=DIME.
  - Else nickel_cnt>0 -> FIRE with coin=NICKEL.
  - Else -> FAULT.
  - Example: amount 3 with zero dimes uses three nickels.
- FIRE (1 cycle): assert hop10_fire or hop5_fire according to coin, then go to WAIT. Never both at once.
- WAIT:
  - On hop_done, remaining decreases by 2 (dime) or 1 (nickel), the matching counter decrements, and the FSM returns to SELECT.
  - Counters never underflow; this is guaranteed by the SELECT checks.
- DONE (1 cycle): done=1, then IDLE.
- FAULT:
  - short_fault=1 and owed=remaining, both held until clear_fault.
  - clear_fault returns to IDLE with remaining cleared.
- hop_done outside WAIT is ignored.
- req_valid while busy is not accepted; the requester holds it.
- load_en outside IDLE is ignored.
- Latency per coin is 3 cycles minimum (SELECT, FIRE, WAIT with immediate hop_done). A zero amount completes as accept -> SELECT -> DONE pulse, then IDLE.

Optional Feature:
- Macro: HOPPER_TIMEOUT_EN.
- With it defined:
  - A timer clears on entry to WAIT and counts each WAIT cycle.
  - If it reaches HOP_TIMEOUT-1 without hop_done, the FSM goes to FAULT.
  - The fired coin is not counted: neither remaining nor the inventory counter decrements.
  - hop_done in the timeout cycle wins over the timeout.
- Without it: WAIT waits indefinitely, and no timer logic is present.

Test Plan:
- Load 5 dimes and 5 nickels; request 5 (25 cents) with hop_done 1 cycle after each fire -> hop10_fire, hop10_fire, hop5_fire in that order, then a done pulse; dime_cnt=3, nickel_cnt=4, owed=0.
- Load 0 dimes and 4 nickels; request 3 -> three hop5_fire pulses and no hop10_fire; done=1; nickel_cnt=1.
- Load 1 dime and 0 nickels; request 3 -> one dime fires, then FAULT with owed=1 and short_fault=1; clear_fault returns to IDLE with req_ready=1.
- Request 4 with a second req_valid and load_en asserted mid-dispense -> req_ready=0, the second request is not accepted, counters are unaffected by the load; exactly 2 dime pulses.
- Assert rst while in WAIT after the first hop10_fire -> immediately IDLE, counters 0, no further fire pulses, done never asserts.
- With HOPPER_TIMEOUT_EN and HOP_TIMEOUT=16: fire with hop_done withheld -> FAULT 15 WAIT cycles after FIRE, owed equals the full amount, dime_cnt unchanged.
